// File: rtl/spi_master_burst.sv
// Full-duplex SPI master with multi-word bursts: CS held low until a word tagged last completes.
// First SCLK edge 1+half-period clk after handshake; tx_ready only in IDLE/WAIT, rx_valid has no backpressure.
module spi_master_burst #(
   parameter  int DATA_W = 8,
   parameter  int CS_NUM = 1,
   parameter  int DIV_W  = 8,
   localparam int CS_W   = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DIV_W-1:0]  spi_clk_div,
   input  logic              cfg_cpol,
   input  logic              cfg_cpha,
   input  logic              cfg_lsb_first,
   input  logic [CS_W-1:0]   cs_sel,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_last,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              spi_clk,
   output logic [CS_NUM-1:0] spi_cs_n,
   output logic              spi_mosi,
   input  logic              spi_miso
);

   localparam int EW = $clog2(2 * DATA_W + 1);
   localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_SHIFT, S_WAIT, S_HOLD, S_DEASSERT
   } state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [EW-1:0]     edge_q, edge_d;
   logic              cpha_q, cpha_d;
   logic              lsb_q, lsb_d;
   logic              last_q, last_d;
   logic              pend_q, pend_d;
   logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              tx_ready_q, tx_ready_d;
   logic              busy_q, busy_d;
   logic              sclk_q, sclk_d;
   logic [CS_NUM-1:0] cs_n_q, cs_n_d;
   logic              mosi_q, mosi_d;

   logic              hs;
   logic              expire;
   logic [EW-1:0]     edge_nxt;
   logic              sample_now;
   logic              shift_now;
   logic [DATA_W-1:0] rx_next;
   logic [CS_NUM-1:0] cs_dec;

   function automatic logic first_bit(input logic [DATA_W-1:0] d, input logic lsb);
      return lsb ? d[0] : d[DATA_W-1];
   endfunction

   function automatic logic [DATA_W-1:0] shifted(input logic [DATA_W-1:0] d, input logic lsb);
      return lsb ? (d >> 1) : (d << 1);
   endfunction

   // An out-of-range cs_sel matches no index, leaving every select high.
   always_comb begin
      for (int i = 0; i < CS_NUM; i++) begin
         cs_dec[i] = (cs_sel != CS_W'(i));
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      div_d      = div_q;
      edge_d     = edge_q;
      cpha_d     = cpha_q;
      lsb_d      = lsb_q;
      last_d     = last_q;
      pend_d     = pend_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      sclk_d     = sclk_q;
      cs_n_d     = cs_n_q;
      mosi_d     = mosi_q;

      hs         = tx_valid && tx_ready_q;
      expire     = (cnt_q == '0);
      edge_nxt   = edge_q + 1'b1;
      sample_now = cpha_q ? !edge_nxt[0] : edge_nxt[0];
      shift_now  = cpha_q ? edge_nxt[0] : (!edge_nxt[0] && (edge_nxt != LAST_EDGE));
      rx_next    = lsb_q ? {spi_miso, rx_shift_q[DATA_W-1:1]}
                         : {rx_shift_q[DATA_W-2:0], spi_miso};

      case (state_q)
         S_IDLE: begin
            sclk_d = cfg_cpol;
            cs_n_d = '1;
            if (hs) begin
               cpha_d = cfg_cpha;
               lsb_d  = cfg_lsb_first;
               div_d  = spi_clk_div;
               cnt_d  = spi_clk_div;
               last_d = tx_last;
               cs_n_d = cs_dec;
               if (!cfg_cpha) begin
                  mosi_d     = first_bit(tx_data, cfg_lsb_first);
                  tx_shift_d = shifted(tx_data, cfg_lsb_first);
               end else begin
                  tx_shift_d = tx_data;
               end
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            // Leaving with cnt at zero makes the first SHIFT cycle an edge.
            if (expire) begin
               edge_d  = '0;
               state_d = S_SHIFT;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_SHIFT: begin
            if (expire) begin
               cnt_d  = div_q;
               sclk_d = ~sclk_q;
               edge_d = edge_nxt;
               if (sample_now) rx_shift_d = rx_next;
               if (shift_now) begin
                  mosi_d     = first_bit(tx_shift_q, lsb_q);
                  tx_shift_d = shifted(tx_shift_q, lsb_q);
               end
               if (edge_nxt == LAST_EDGE) begin
                  rx_data_d  = sample_now ? rx_next : rx_shift_q;
                  rx_valid_d = 1'b1;
                  pend_d     = 1'b0;
                  state_d    = last_q ? S_HOLD : S_WAIT;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_WAIT: begin
            if (pend_q) begin
               if (expire) begin
                  edge_d  = '0;
                  state_d = S_SHIFT;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end else if (hs) begin
               last_d = tx_last;
               cnt_d  = div_q;
               pend_d = 1'b1;
               if (!cpha_q) begin
                  mosi_d     = first_bit(tx_data, lsb_q);
                  tx_shift_d = shifted(tx_data, lsb_q);
               end else begin
                  tx_shift_d = tx_data;
               end
            end
         end
         S_HOLD: begin
            if (expire) begin
               cs_n_d  = '1;
               cnt_d   = div_q;
               state_d = S_DEASSERT;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DEASSERT: begin
            if (expire) state_d = S_IDLE;
            else        cnt_d = cnt_q - 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      tx_ready_d = (state_d == S_IDLE) || ((state_d == S_WAIT) && !pend_d);
      busy_d     = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         div_q      <= '0;
         edge_q     <= '0;
         cpha_q     <= 1'b0;
         lsb_q      <= 1'b0;
         last_q     <= 1'b0;
         pend_q     <= 1'b0;
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         tx_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         sclk_q     <= 1'b0;
         cs_n_q     <= '1;
         mosi_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         edge_q     <= edge_d;
         cpha_q     <= cpha_d;
         lsb_q      <= lsb_d;
         last_q     <= last_d;
         pend_q     <= pend_d;
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tx_ready_q <= tx_ready_d;
         busy_q     <= busy_d;
         sclk_q     <= sclk_d;
         cs_n_q     <= cs_n_d;
         mosi_q     <= mosi_d;
      end
   end

   assign tx_ready = tx_ready_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign busy     = busy_q;
   assign spi_clk  = sclk_q;
   assign spi_cs_n = cs_n_q;
   assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_burst.sv
// Directed bench for spi_master_burst: expected rx words are queued at issue and
// checked by a monitor on each rx_valid; MOSI is captured on SCLK edges.
module tb_spi_master_burst;

   localparam int NCS = 5;

   logic           clk = 1'b0;
   logic           rst;
   logic [7:0]     spi_clk_div;
   logic           cfg_cpol, cfg_cpha, cfg_lsb_first;
   logic [2:0]     cs_sel;
   logic [7:0]     tx_data;
   logic           tx_last, tx_valid, tx_ready;
   logic [7:0]     rx_data;
   logic           rx_valid, busy, spi_clk, spi_mosi, spi_miso;
   logic [NCS-1:0] spi_cs_n;
   logic           miso_tie;

   int checks = 0;
   int failures = 0;

   logic [7:0] exp_q[$];
   logic       rise_q[$];
   logic       fall_q[$];
   int         edges, gap_min, gap_max, cyc_since, rx_pulses, ready_bad, cs2_rise;
   int         cs_low[NCS];
   logic       sclk_prev, cs2_prev;

   assign spi_miso = miso_tie ? 1'b1 : spi_mosi;

   always #5 clk = ~clk;

   spi_master_burst #(.DATA_W(8), .CS_NUM(NCS), .DIV_W(8)) dut (
      .clk(clk), .rst(rst), .spi_clk_div(spi_clk_div),
      .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_lsb_first(cfg_lsb_first),
      .cs_sel(cs_sel), .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
      .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: SCLK edges, CS activity and scoreboard pops, sampled mid-cycle.
   initial begin : monitor
      sclk_prev = 1'b0;
      cs2_prev  = 1'b1;
      cyc_since = 0;
      rx_pulses = 0;
      forever begin
         @(negedge clk);
         cyc_since++;
         if (!rst && spi_clk !== sclk_prev) begin
            edges++;
            if (spi_clk) rise_q.push_back(spi_mosi);
            else         fall_q.push_back(spi_mosi);
            if (edges > 1) begin
               if (cyc_since < gap_min) gap_min = cyc_since;
               if (cyc_since > gap_max) gap_max = cyc_since;
            end
            cyc_since = 0;
         end
         sclk_prev = spi_clk;
         if (!rst && tx_ready && spi_clk !== cfg_cpol) ready_bad++;
         for (int i = 0; i < NCS; i++) if (!spi_cs_n[i]) cs_low[i]++;
         if (spi_cs_n[2] && !cs2_prev) cs2_rise++;
         cs2_prev = spi_cs_n[2];
         if (rx_valid) begin
            rx_pulses++;
            if (exp_q.size() == 0) check("rx_unexpected", 32'(rx_data), 32'hDEAD);
            else                   check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog expired");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end

   task automatic clear_mon();
      edges = 0; gap_min = 1000; gap_max = 0; ready_bad = 0; cs2_rise = 0;
      rise_q.delete(); fall_q.delete();
      for (int i = 0; i < NCS; i++) cs_low[i] = 0;
   endtask

   task automatic cfg(input logic cpol, input logic cpha, input logic lsb,
                      input logic [7:0] div, input logic [2:0] cs);
      @(posedge clk); #1;
      cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb_first = lsb; spi_clk_div = div; cs_sel = cs;
      repeat (3) @(posedge clk);
      #1 clear_mon();
   endtask

   task automatic send(input logic [7:0] d, input logic last, input logic push, input logic [7:0] exp);
      logic ok;
      if (push) exp_q.push_back(exp);
      @(posedge clk); #1;
      tx_data = d; tx_last = last; tx_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (tx_ready) begin ok = 1'b1; break; end
      end
      check("tx_accept", 32'(ok), 32'd1);
      @(posedge clk); #1;
      tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!busy) begin ok = 1'b1; break; end
      end
      check("idle_reached", 32'(ok), 32'd1);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_bits(input string name, input logic q[$], input logic [7:0] exp, input logic lsb);
      logic [7:0] v;
      v = '0;
      check({name, "_count"}, 32'(q.size()), 32'd8);
      foreach (q[i]) v = lsb ? {q[i], v[7:1]} : {v[6:0], q[i]};
      check(name, 32'(v), 32'(exp));
   endtask

   int p0;
   logic ok5;

   initial begin : stim
      rst = 1'b1; miso_tie = 1'b0;
      spi_clk_div = 8'd0; cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0;
      cs_sel = 3'd0; tx_data = 8'd0; tx_last = 1'b0; tx_valid = 1'b0;
      clear_mon();
      repeat (3) @(negedge clk);
      check("rst_spi_clk", 32'(spi_clk), 32'd0);
      check("rst_cs_n", 32'(spi_cs_n), 32'h1F);
      check("rst_mosi", 32'(spi_mosi), 32'd0);
      check("rst_tx_ready", 32'(tx_ready), 32'd0);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;

      // Mode 3, MSB first, div 2
      cfg(1'b1, 1'b1, 1'b0, 8'd2, 3'd0);
      p0 = rx_pulses;
      send(8'hF4, 1'b1, 1'b1, 8'hF4);
      wait_idle();
      check_bits("t1_mosi_rise", rise_q, 8'hF4, 1'b0);
      check("t1_edges", 32'(edges), 32'd16);
      check("t1_gap_min", 32'(gap_min), 32'd3);
      check("t1_gap_max", 32'(gap_max), 32'd3);
      check("t1_rx_pulses", 32'(rx_pulses - p0), 32'd1);
      check("t1_cs0_low_ge_word", 32'(cs_low[0] >= 48), 32'd1);
      check("t1_other_cs", 32'(cs_low[1] + cs_low[2] + cs_low[3] + cs_low[4]), 32'd0);
      check("t1_sclk_idle", 32'(spi_clk), 32'd1);

      // Mode 0, LSB first, div 0, miso tied high
      miso_tie = 1'b1;
      cfg(1'b0, 1'b0, 1'b1, 8'd0, 3'd0);
      send(8'hA5, 1'b1, 1'b1, 8'hFF);
      wait_idle();
      check_bits("t2_mosi_rise", rise_q, 8'hA5, 1'b1);
      check("t2_gap", 32'(gap_max), 32'd1);
      check("t2_sclk_idle", 32'(spi_clk), 32'd0);
      miso_tie = 1'b0;

      // Three-word burst on CS 2 with gaps between words
      cfg(1'b0, 1'b0, 1'b0, 8'd1, 3'd2);
      p0 = rx_pulses;
      send(8'h01, 1'b0, 1'b1, 8'h01);
      repeat (60) @(posedge clk);
      #1;
      check("t3_wait_cs_low", 32'(spi_cs_n[2]), 32'd0);
      check("t3_wait_ready", 32'(tx_ready), 32'd1);
      check("t3_wait_busy", 32'(busy), 32'd1);
      send(8'h02, 1'b0, 1'b1, 8'h02);
      repeat (60) @(posedge clk);
      send(8'h03, 1'b1, 1'b1, 8'h03);
      wait_idle();
      check("t3_rx_pulses", 32'(rx_pulses - p0), 32'd3);
      check("t3_cs2_single_release", 32'(cs2_rise), 32'd1);
      check("t3_other_cs", 32'(cs_low[0] + cs_low[1] + cs_low[3] + cs_low[4]), 32'd0);
      check("t3_ready_outside_idle_wait", 32'(ready_bad), 32'd0);
      check("t3_edges", 32'(edges), 32'd48);

      // Out-of-range chip select
      cfg(1'b0, 1'b0, 1'b0, 8'd1, 3'd5);
      p0 = rx_pulses;
      send(8'h3C, 1'b1, 1'b1, 8'h3C);
      wait_idle();
      check("t4_no_cs", 32'(cs_low[0] + cs_low[1] + cs_low[2] + cs_low[3] + cs_low[4]), 32'd0);
      check("t4_edges", 32'(edges), 32'd16);
      check("t4_rx_pulses", 32'(rx_pulses - p0), 32'd1);

      // Reset mid-word
      cfg(1'b0, 1'b0, 1'b0, 8'd1, 3'd0);
      p0 = rx_pulses;
      send(8'h96, 1'b1, 1'b0, 8'h00);
      ok5 = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk);
         if (edges >= 7) begin ok5 = 1'b1; break; end
      end
      check("t5_reach_edge7", 32'(ok5), 32'd1);
      #1 rst = 1'b1;
      @(negedge clk);
      check("t5_cs_n", 32'(spi_cs_n), 32'h1F);
      check("t5_spi_clk", 32'(spi_clk), 32'd0);
      check("t5_busy", 32'(busy), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (40) @(posedge clk);
      check("t5_no_rx_valid", 32'(rx_pulses - p0), 32'd0);
      cfg(1'b0, 1'b0, 1'b0, 8'd1, 3'd0);
      send(8'h5A, 1'b1, 1'b1, 8'h5A);
      wait_idle();
      check("t5_after_rx_pulses", 32'(rx_pulses - p0), 32'd1);

      // Mode 1 then mode 2, both sample on the falling edge
      cfg(1'b0, 1'b1, 1'b0, 8'd1, 3'd1);
      send(8'h81, 1'b1, 1'b1, 8'h81);
      wait_idle();
      check_bits("t6_m1_mosi_fall", fall_q, 8'h81, 1'b0);
      check("t6_m1_sclk_idle", 32'(spi_clk), 32'd0);
      cfg(1'b1, 1'b0, 1'b0, 8'd1, 3'd1);
      send(8'h81, 1'b1, 1'b1, 8'h81);
      wait_idle();
      check_bits("t6_m2_mosi_fall", fall_q, 8'h81, 1'b0);
      check("t6_m2_sclk_idle", 32'(spi_clk), 32'd1);

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
